// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the 16-bit sequencer: opcodes, FSM states and
// instruction field positions.
package core_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RC_HI  = 11;
  localparam int RC_LO  = 8;
  localparam int RA_HI  = 7;
  localparam int RA_LO  = 4;
  localparam int RB_HI  = 3;
  localparam int RB_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Only the ALU ops and LDI write the register file.
  function automatic logic writes_rf(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_LDI);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction-memory and register-file bus seen by the sequencer.
interface core_sequencer_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 16
);
  import core_pkg::*;

  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_data;
  logic [3:0]        ra_adr;
  logic [3:0]        rb_adr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic [3:0]        rc_adr;
  logic [DATA_W-1:0] rc_data;
  logic              wen;

  modport master (
    output imem_addr, ra_adr, rb_adr, rc_adr, rc_data, wen,
    input  imem_data, ra_data, rb_data
  );

  modport slave (
    input  imem_addr, ra_adr, rb_adr, rc_adr, rc_data, wen,
    output imem_data, ra_data, rb_data
  );
endinterface

// File: rtl/core_sequencer_alu16.sv
// Combinational ALU: opcode plus two operands to one result, modulo 2^16.
module alu16
  import core_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  // Result select; non-ALU opcodes produce zero.
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_SHL:  y_o = a_i << b_i[3:0];
      OP_SHR:  y_o = a_i >> b_i[3:0];
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Four-cycle fetch/decode/execute/writeback sequencer driving the register
// file ports; every output comes straight from a register.
module core_sequencer
  import core_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  core_sequencer_if.master       bus,
  output logic                   retire,
  output logic                   halted
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   next_pc_q, next_pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [3:0]        ra_adr_q, ra_adr_d;
  logic [3:0]        rb_adr_q, rb_adr_d;
  logic [3:0]        rc_adr_q, rc_adr_d;
  logic [DATA_W-1:0] rc_data_q, rc_data_d;
  logic              wen_q, wen_d;
  logic              retire_q, retire_d;
  logic              halted_q, halted_d;

  logic [3:0]        op;
  logic [PC_W-1:0]   imm_pc;
  logic [PC_W-1:0]   pc_inc;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] result;

  assign op     = ir_q[OP_HI:OP_LO];
  assign imm_pc = PC_W'(ir_q[IMM_HI:IMM_LO]);
  assign pc_inc = pc_q + PC_W'(1);
  assign result = (op == OP_LDI) ? DATA_W'({8'h00, ir_q[IMM_HI:IMM_LO]}) : alu_y;

  alu16 #(.DATA_W(DATA_W)) u_alu (
    .op_i (op),
    .a_i  (bus.ra_data),
    .b_i  (bus.rb_data),
    .y_o  (alu_y)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic: fixed 4-cycle loop, stall only in FETCH, HALT is terminal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (run) state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = (op == OP_HALT) ? HALT : FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Per-state next values for the datapath and registered outputs.
  always_comb begin
    ir_d      = ir_q;
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    ra_adr_d  = ra_adr_q;
    rb_adr_d  = rb_adr_q;
    rc_adr_d  = rc_adr_q;
    rc_data_d = rc_data_q;
    wen_d     = 1'b0;
    retire_d  = 1'b0;
    halted_d  = halted_q;
    case (state_q)
      FETCH: begin
        if (run) ir_d = bus.imem_data;
      end
      DECODE: begin
        // BZ tests the register named in the rc field, so route it to port A.
        ra_adr_d = (op == OP_BZ) ? ir_q[RC_HI:RC_LO] : ir_q[RA_HI:RA_LO];
        rb_adr_d = ir_q[RB_HI:RB_LO];
      end
      EXEC: begin
        rc_adr_d  = ir_q[RC_HI:RC_LO];
        rc_data_d = result;
        wen_d     = writes_rf(op);
        retire_d  = 1'b1;
        case (op)
          OP_JMP:  next_pc_d = imm_pc;
          OP_BZ:   next_pc_d = (bus.ra_data == '0) ? imm_pc : pc_inc;
          OP_HALT: next_pc_d = pc_q;
          default: next_pc_d = pc_inc;
        endcase
      end
      WB: begin
        pc_d     = next_pc_q;
        halted_d = (op == OP_HALT);
      end
      default: ;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      ra_adr_q  <= '0;
      rb_adr_q  <= '0;
      rc_adr_q  <= '0;
      rc_data_q <= '0;
      wen_q     <= 1'b0;
      retire_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ra_adr_q  <= ra_adr_d;
      rb_adr_q  <= rb_adr_d;
      rc_adr_q  <= rc_adr_d;
      rc_data_q <= rc_data_d;
      wen_q     <= wen_d;
      retire_q  <= retire_d;
      halted_q  <= halted_d;
    end
  end

  // Instruction and branch-target holding registers; always written before use.
  always_ff @(posedge clk) begin
    ir_q      <= ir_d;
    next_pc_q <= next_pc_d;
  end

  assign bus.imem_addr = pc_q;
  assign bus.ra_adr    = ra_adr_q;
  assign bus.rb_adr    = rb_adr_q;
  assign bus.rc_adr    = rc_adr_q;
  assign bus.rc_data   = rc_data_q;
  assign bus.wen       = wen_q;
  assign retire        = retire_q;
  assign halted        = halted_q;

endmodule
